// File: rtl/truth_table_probe_pkg.sv
// Shared types and sizing for the truth-table probe: FSM state encoding,
// truth-table width helper and the settle/sample counter width.
package truth_table_probe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Wide enough for the largest settle interval (255 cycles).
  localparam int CNT_W = 8;
  localparam int N_IN_MAX = 4;

  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/probe_timer.sv
// Shared settle/sample down-counter: loads a preset, counts to zero and
// holds there; tc flags the final cycle of the current interval.
module probe_timer
  import truth_table_probe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - ONE;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == '0);

endmodule

// File: rtl/truth_table_probe.sv
// Walks every input vector of a small combinational circuit, waits for it to
// settle, samples the response and returns the packed truth table.
module truth_table_probe
  import truth_table_probe_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 2
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic [tt_w(N_IN)-1:0]   tt,
  output logic                    unstable,
  output logic                    tt_valid,
  input  logic                    tt_ready
);

  localparam int TT_W = tt_w(N_IN);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLES - 1);
  localparam logic [N_IN-1:0]  ROW_ONE     = N_IN'(1);

  state_t            state_reg, state_next;
  logic [N_IN-1:0]   row_reg, row_next;
  logic [TT_W-1:0]   tt_reg, tt_next;
  logic              unstable_reg, unstable_next;
  logic              busy_reg, busy_next;
  logic              valid_reg, valid_next;
  logic              prev_reg, prev_next;

  logic              timer_load;
  logic [CNT_W-1:0]  timer_value;
  logic [CNT_W-1:0]  timer_count;
  logic              timer_tc;

  logic              begin_run;
  logic              last_row;
  logic [N_IN-1:0]   bit_idx;

  probe_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .count      (timer_count),
    .tc         (timer_tc)
  );

  // Row r lands at bit TT_W-1-r, which in N_IN bits is simply ~r.
  assign bit_idx  = ~row_reg;
  assign last_row = &row_reg;
  assign begin_run = start &&
                     ((state_reg == IDLE) || ((state_reg == DONE) && tt_ready));

  always_comb begin
    state_next    = state_reg;
    row_next      = row_reg;
    tt_next       = tt_reg;
    unstable_next = unstable_reg;
    busy_next     = busy_reg;
    valid_next    = valid_reg;
    prev_next     = prev_reg;
    timer_load    = 1'b0;
    timer_value   = SETTLE_LOAD;

    case (state_reg)
      SETTLE: begin
        if (timer_tc) begin
          state_next  = SAMPLE;
          timer_load  = 1'b1;
          timer_value = SAMPLE_LOAD;
        end
      end
      SAMPLE: begin
        // The first sample of a row has nothing to be compared against.
        if ((timer_count != SAMPLE_LOAD) && (dut_out != prev_reg)) begin
          unstable_next = 1'b1;
        end
        prev_next        = dut_out;
        tt_next[bit_idx] = dut_out;
        if (timer_tc) begin
          if (last_row) begin
            state_next = DONE;
            busy_next  = 1'b0;
            valid_next = 1'b1;
          end else begin
            state_next  = SETTLE;
            row_next    = row_reg + ROW_ONE;
            timer_load  = 1'b1;
            timer_value = SETTLE_LOAD;
          end
        end
      end
      DONE: begin
        if (tt_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      end
      default: begin
      end
    endcase

    if (begin_run) begin
      state_next    = SETTLE;
      row_next      = '0;
      tt_next       = '0;
      unstable_next = 1'b0;
      busy_next     = 1'b1;
      valid_next    = 1'b0;
      timer_load    = 1'b1;
      timer_value   = SETTLE_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      row_reg      <= '0;
      tt_reg       <= '0;
      unstable_reg <= 1'b0;
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      prev_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_reg      <= row_next;
      tt_reg       <= tt_next;
      unstable_reg <= unstable_next;
      busy_reg     <= busy_next;
      valid_reg    <= valid_next;
      prev_reg     <= prev_next;
    end
  end

  assign dut_in   = row_reg;
  assign tt       = tt_reg;
  assign unstable = unstable_reg;
  assign busy     = busy_reg;
  assign tt_valid = valid_reg;

endmodule

// File: tb/tb_truth_table_probe.sv
// Randomised bench for truth_table_probe: a cycle-level behavioural model
// predicts every output, plus hand-computed expectations for known circuits.
module tb_truth_table_probe;

  localparam int S    = 4;
  localparam int M    = 2;
  localparam int PER  = S + M;
  localparam int ROWS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, tt_ready, dut_out;
  logic [2:0] dut_in;
  logic       busy, unstable, tt_valid;
  logic [7:0] tt;

  logic       start_b, ready_b, one_b;
  logic [2:0] dut_in_b;
  logic       busy_b, unstable_b, valid_b;
  logic [7:0] tt_b;

  int         n_vec  = 0;
  int         n_fail = 0;
  int         mode   = 0;
  logic [7:0] tbl    = 8'h00;
  logic       tog    = 1'b0;

  always @(negedge clk) tog <= ~tog;

  // Circuit under test: 0 = reference function, 1 = same but row 3 toggles
  // every cycle, 2 = arbitrary lookup table.
  function automatic logic circuit(input logic [2:0] x, input int md,
                                   input logic tg, input logic [7:0] tb);
    logic f;
    f = (~x[2] & x[1]) ^ x[0];
    case (md)
      0:       return f;
      1:       return (x == 3'd3) ? tg : f;
      default: return tb[x];
    endcase
  endfunction

  assign dut_out = circuit(dut_in, mode, tog, tbl);
  assign one_b   = 1'b1;

  truth_table_probe #(.N_IN(3), .SETTLE_CYCLES(S), .SAMPLES(M)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .tt(tt), .unstable(unstable), .tt_valid(tt_valid),
    .tt_ready(tt_ready)
  );

  truth_table_probe #(.N_IN(3), .SETTLE_CYCLES(1), .SAMPLES(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(one_b),
    .busy(busy_b), .tt(tt_b), .unstable(unstable_b), .tt_valid(valid_b),
    .tt_ready(ready_b)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: k counts edges since the accept edge; each row takes
  // PER edges, the last M of which are samples.
  logic       m_run = 0, m_busy = 0, m_valid = 0, m_un = 0;
  logic       m_first = 0, m_diff = 0;
  logic [2:0] m_din = 0;
  logic [7:0] m_tt = 0;
  int         m_k = 0;

  always @(posedge clk) begin : model
    int k, r, pos;
    logic run, bsy, vld, un, first, diff, v;
    logic [2:0] din;
    logic [7:0] tv;
    k = m_k; run = m_run; bsy = m_busy; vld = m_valid; un = m_un;
    first = m_first; diff = m_diff; din = m_din; tv = m_tt;
    if (rst) begin
      k = 0; run = 0; bsy = 0; vld = 0; un = 0; din = 0; tv = 0;
    end else if (start && (m_valid ? tt_ready : !m_run)) begin
      k = 0; run = 1; bsy = 1; vld = 0; un = 0; din = 0; tv = 0;
    end else if (m_valid && tt_ready) begin
      vld = 0;
    end else if (m_run) begin
      k++;
      r   = (k - 1) / PER;
      pos = (k - 1) % PER;
      if (pos >= S) begin
        v = circuit(m_din, mode, tog, tbl);
        if (pos == S) begin
          first = v;
          diff  = 0;
        end else if (v != first) begin
          diff = 1;
        end
        if (pos == PER - 1) begin
          tv[ROWS - 1 - r] = v;
          if (diff) un = 1;
          if (r == ROWS - 1) begin
            run = 0; bsy = 0; vld = 1;
          end else begin
            din = 3'(r + 1);
          end
        end
      end
    end
    m_k <= k; m_run <= run; m_busy <= bsy; m_valid <= vld; m_un <= un;
    m_first <= first; m_diff <= diff; m_din <= din; m_tt <= tv;
  end

  always @(negedge clk) begin
    check("dut_in", dut_in, m_din);
    check("busy", busy, m_busy);
    check("tt_valid", tt_valid, m_valid);
    if (m_valid) begin
      check("tt", tt, m_tt);
      check("unstable", unstable, m_un);
    end
  end

  task automatic wait_result(input bit noise, output int lat);
    lat = 0;
    while (!tt_valid && lat < 300) begin
      @(negedge clk);
      lat++;
      start = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
    end
    start = 1'b0;
    check("valid_timeout", tt_valid, 1);
  endtask

  task automatic hold_done(input int cycles);
    repeat (cycles) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic handshake(input bit restart);
    tt_ready = 1'b1;
    start    = restart;
    @(negedge clk);
    tt_ready = 1'b0;
    start    = 1'b0;
    check("hs_busy", busy, restart);
    check("hs_valid", tt_valid, 0);
  endtask

  task automatic run_a(input int md, input bit noise, input int delay,
                       input bit pin);
    int lat;
    mode = md;
    if (md == 2) tbl = 8'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result(noise, lat);
    if (pin) begin
      check("latency", lat, 48);
      if (md == 0) begin
        check("tt_ref", tt, 8'h65);
        check("unstable_ref", unstable, 0);
      end else if (md == 1) begin
        check("unstable_toggle", unstable, 1);
        check("tt_toggle_others", tt & 8'hEF, 8'h65 & 8'hEF);
      end
    end
    hold_done(delay);
    handshake(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; tt_ready = 1'b0; start_b = 1'b0; ready_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tt", tt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", tt_valid, 0);
    check("rst_dut_in", dut_in, 0);
    rst = 1'b0;
    @(negedge clk);

    // Constant-1 circuit, one settle cycle and one sample per row.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    lat = 0;
    while (!valid_b && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("b_latency", lat, 16);
    check("b_tt", tt_b, 8'hFF);
    check("b_unstable", unstable_b, 0);
    check("b_busy", busy_b, 0);
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    check("b_valid_drop", valid_b, 0);

    run_a(0, 1'b1, 0, 1'b1);
    run_a(1, 1'b1, 3, 1'b1);

    // Stalled handshake with stray starts, then restart on the handshake.
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result(1'b0, lat);
    hold_done(10);
    check("held_tt", tt, 8'h65);
    check("held_valid", tt_valid, 1);
    handshake(1'b1);
    wait_result(1'b1, lat);
    check("restart_latency", lat, 48);
    check("restart_tt", tt, 8'h65);
    handshake(1'b0);

    for (int i = 0; i < 6; i++) begin
      run_a($urandom_range(0, 2), 1'b1, $urandom_range(0, 4), 1'b0);
    end

    // Reset in the middle of row 4, with a start that must be ignored.
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (dut_in != 3'd4 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("row4_reached", dut_in, 4);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("midrst_dut_in", dut_in, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tt", tt, 0);
    check("midrst_unstable", unstable, 0);
    check("midrst_valid", tt_valid, 0);
    @(negedge clk);
    check("midrst_idle", busy, 0);
    run_a(0, 1'b0, 0, 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
